// File: rtl/mic_spi_scheduler.sv
// ============================================================================
// Module   : mic_spi_scheduler
// Brief    : Round-robin arbiter that hands 4 microphone channel words to a
//            parallel-to-serial SPI stage. Optional macro P2S_WATCHDOG_EN
//            enables a busy-handshake watchdog with a sticky error flag.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mic_spi_scheduler #(
    parameter int DW           = 12,
    parameter int BUSY_TIMEOUT = 255
) (
    input  logic            clkin,
    input  logic            rst_bar,
    input  logic            en,
    input  logic [3:0]      req,
    input  logic [4*DW-1:0] ch_data,
    output logic [3:0]      ack,
    input  logic            ser_busy,
    output logic            ser_load,
    output logic [DW-1:0]   ser_word,
    output logic [1:0]      ser_ch,
    output logic            wd_err
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GRANT     = 3'd1,
        LOAD      = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4
    } state_t;

    state_t     state;
    logic [1:0] grant_ch;
    logic [1:0] last_ch;
    logic [1:0] next_ch;
    logic       wd_hit;

    // Round-robin search starting one past the last served channel.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        next_ch = last_ch;
        found   = 1'b0;
        idx     = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            idx = last_ch + 2'(i);
            if (!found && req[idx]) begin
                next_ch = idx;
                found   = 1'b1;
            end
        end
    end

`ifdef P2S_WATCHDOG_EN
    logic [7:0] wd_cnt;

    assign wd_hit = (state == WAIT_BUSY || state == WAIT_DONE) &&
                    (wd_cnt == 8'(BUSY_TIMEOUT));

    always_ff @(posedge clkin or negedge rst_bar) begin
        if (!rst_bar) begin
            wd_cnt <= 8'd0;
            wd_err <= 1'b0;
        end else if (state == WAIT_BUSY || state == WAIT_DONE) begin
            if (wd_hit) begin
                wd_cnt <= 8'd0;
                wd_err <= 1'b1;
            end else begin
                wd_cnt <= wd_cnt + 8'd1;
            end
        end else begin
            wd_cnt <= 8'd0;
        end
    end
`else
    assign wd_hit = 1'b0;
    assign wd_err = 1'b0;
`endif

    always_ff @(posedge clkin or negedge rst_bar) begin
        if (!rst_bar) begin
            state    <= IDLE;
            ack      <= 4'd0;
            ser_load <= 1'b0;
            ser_word <= '0;
            ser_ch   <= 2'd0;
            grant_ch <= 2'd0;
            last_ch  <= 2'd3;
        end else begin
            case (state)
                IDLE: begin
                    if (en && (req != 4'd0)) begin
                        grant_ch <= next_ch;
                        ack      <= 4'b0001 << next_ch;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    ack      <= 4'd0;
                    ser_word <= ch_data[grant_ch*DW +: DW];
                    ser_ch   <= grant_ch;
                    ser_load <= 1'b1;
                    state    <= LOAD;
                end
                LOAD: begin
                    ser_load <= 1'b0;
                    state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (wd_hit) begin
                        last_ch <= grant_ch;
                        state   <= IDLE;
                    end else if (ser_busy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (wd_hit || !ser_busy) begin
                        last_ch <= grant_ch;
                        state   <= IDLE;
                    end
                end
                default: begin
                    ack      <= 4'd0;
                    ser_load <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mic_spi_scheduler.sv
// ============================================================================
// Module   : tb_mic_spi_scheduler
// Brief    : Scoreboard bench for mic_spi_scheduler; honours P2S_WATCHDOG_EN.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mic_spi_scheduler;

    localparam int DW = 12;

    typedef struct packed {
        logic [1:0]    ch;
        logic [DW-1:0] word;
    } exp_t;

    logic            clkin = 1'b0;
    logic            rst_bar;
    logic            en;
    logic [3:0]      req;
    logic [4*DW-1:0] ch_data;
    logic [3:0]      ack;
    logic            ser_busy;
    logic            ser_load;
    logic [DW-1:0]   ser_word;
    logic [1:0]      ser_ch;
    logic            wd_err;

    int total = 0;
    int bad   = 0;
    int n_ack = 0;
    int n_load = 0;
    exp_t exp_q[$];
    logic [DW-1:0] words[4] = '{12'h123, 12'hA5C, 12'h7E1, 12'h3D4};

    logic ser_en     = 1'b1;
    logic ser_active = 1'b0;
    int   busy_delay = 12;
    int   busy_len   = 5;
    logic prev_ack   = 1'b0;
    logic [3:0] prev_ack_v = 4'd0;

    mic_spi_scheduler #(.DW(DW), .BUSY_TIMEOUT(255)) dut (
        .clkin   (clkin),
        .rst_bar (rst_bar),
        .en      (en),
        .req     (req),
        .ch_data (ch_data),
        .ack     (ack),
        .ser_busy(ser_busy),
        .ser_load(ser_load),
        .ser_word(ser_word),
        .ser_ch  (ser_ch),
        .wd_err  (wd_err)
    );

    always #5 clkin = ~clkin;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clkin);
        #1;
    endtask

    task automatic push(input logic [1:0] ch);
        exp_t e;
        e.ch   = ch;
        e.word = words[ch];
        exp_q.push_back(e);
    endtask

    task automatic wait_ack(input int target);
        int k = 0;
        while (n_ack < target && k < 400) begin step(); k++; end
        if (n_ack < target) chk("ack_timeout", 32'(n_ack), 32'(target));
    endtask

    task automatic wait_idle(input int target);
        int k = 0;
        while (!(n_load >= target && !ser_active && !ser_busy) && k < 400) begin step(); k++; end
        if (k >= 400) chk("idle_timeout", 32'(n_load), 32'(target));
        step(2);
    endtask

    // Scoreboard monitor: checks every ack / ser_load against the queue.
    always @(negedge clkin) begin
        if (rst_bar) begin
            if (ack != 4'd0) begin
                n_ack++;
                if (exp_q.size() == 0) chk("unexpected_ack", 32'(ack), 32'd0);
                else chk("ack_onehot", 32'(ack), 32'(4'b0001 << exp_q[0].ch));
            end
            if (ser_load) begin
                n_load++;
                if (exp_q.size() == 0) chk("unexpected_load", 32'(ser_load), 32'd0);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("load_after_ack", 32'(prev_ack_v), 32'(4'b0001 << e.ch));
                    chk("ser_word", 32'(ser_word), 32'(e.word));
                    chk("ser_ch", 32'(ser_ch), 32'(e.ch));
                end
            end
            prev_ack   = (ack != 4'd0);
            prev_ack_v = ack;
        end else begin
            prev_ack   = 1'b0;
            prev_ack_v = 4'd0;
        end
    end

    // Serializer model: raises busy busy_delay cycles after each load.
    initial begin
        ser_busy = 1'b0;
        forever begin
            @(negedge clkin);
            if (ser_en && ser_load && rst_bar) begin
                ser_active = 1'b1;
                repeat (busy_delay) @(posedge clkin);
                #1 ser_busy = 1'b1;
                repeat (busy_len) @(posedge clkin);
                #1 ser_busy = 1'b0;
                ser_active = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int base;
        rst_bar = 1'b0;
        en      = 1'b1;
        req     = 4'd0;
        ch_data = {12'h3D4, 12'h7E1, 12'hA5C, 12'h123};
        step(2);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_load", 32'(ser_load), 32'd0);
        chk("rst_word", 32'(ser_word), 32'd0);
        chk("rst_ch", 32'(ser_ch), 32'd0);
        chk("rst_wd", 32'(wd_err), 32'd0);
        rst_bar = 1'b1;
        step(3);

        // Single request on channel 1, busy 12 cycles after load.
        push(2'd1);
        req = 4'b0010;
        wait_ack(1);
        req = 4'd0;
        wait_idle(1);
        chk("hold_word", 32'(ser_word), 32'h0A5C);
        chk("hold_ch", 32'(ser_ch), 32'd1);

        // Single request on channel 3.
        busy_delay = 1;
        busy_len   = 3;
        push(2'd3);
        req = 4'b1000;
        wait_ack(2);
        req = 4'd0;
        wait_idle(2);

        // All requests held: 0,1,2,3,0,1,2,3.
        for (int i = 0; i < 8; i++) push(2'(i));
        req = 4'b1111;
        wait_ack(10);
        req = 4'd0;
        wait_idle(10);
        chk("rr_count", 32'(n_load), 32'd10);

        // en dropped during WAIT_DONE with channel 0 pending.
        busy_delay = 2;
        busy_len   = 10;
        push(2'd2);
        req = 4'b0100;
        wait_ack(11);
        req = 4'b0001;
        begin
            int k = 0;
            while (!ser_busy && k < 50) begin step(); k++; end
        end
        step();
        en = 1'b0;
        base = n_ack;
        step(30);
        chk("en_off_no_ack", 32'(n_ack), 32'(base));
        chk("en_off_word_done", 32'(n_load), 32'd11);
        push(2'd0);
        en = 1'b1;
        wait_ack(12);
        req = 4'd0;
        wait_idle(12);

        // Reset during WAIT_BUSY; next grant must go to channel 0.
        ser_en = 1'b0;
        push(2'd1);
        req = 4'b0010;
        wait_ack(13);
        req = 4'd0;
        begin
            int k = 0;
            while (n_load < 13 && k < 20) begin step(); k++; end
        end
        step(3);
        rst_bar = 1'b0;
        #1;
        chk("mid_rst_ack", 32'(ack), 32'd0);
        chk("mid_rst_load", 32'(ser_load), 32'd0);
        chk("mid_rst_word", 32'(ser_word), 32'd0);
        chk("mid_rst_ch", 32'(ser_ch), 32'd0);
        chk("mid_rst_wd", 32'(wd_err), 32'd0);
        step(2);
        rst_bar = 1'b1;
        step(3);
        chk("post_rst_no_ack", 32'(n_ack), 32'd13);
        ser_en     = 1'b1;
        busy_delay = 1;
        busy_len   = 3;
        push(2'd0);
        req = 4'b0011;
        wait_ack(14);
        req = 4'd0;
        wait_idle(14);

        // Stalled serializer: watchdog behaviour depends on the build.
        ser_en = 1'b0;
        push(2'd2);
        req = 4'b0100;
        wait_ack(15);
        req = 4'd0;
        step(200);
        chk("wd_not_yet", 32'(wd_err), 32'd0);
        req = 4'b1001;
`ifdef P2S_WATCHDOG_EN
        push(2'd3);
        ser_en = 1'b1;
        begin
            int k = 0;
            while (!wd_err && k < 100) begin step(); k++; end
        end
        chk("wd_set", 32'(wd_err), 32'd1);
        wait_ack(16);
        req = 4'd0;
        wait_idle(16);
        chk("wd_sticky", 32'(wd_err), 32'd1);
`else
        step(100);
        chk("wd_tied_low", 32'(wd_err), 32'd0);
        chk("stall_no_ack", 32'(n_ack), 32'd15);
        push(2'd3);
        ser_en   = 1'b1;
        ser_busy = 1'b1;
        step(2);
        ser_busy = 1'b0;
        wait_ack(16);
        req = 4'd0;
        wait_idle(16);
        chk("wd_still_low", 32'(wd_err), 32'd0);
`endif
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
